// File: rtl/llc_tag_lookup_if.sv
// Request/response bus of the last-level-cache tag lookup block.
// The requester drives the request fields and rsp_ready; the lookup block
// answers with req_ready and the registered response fields.
interface llc_tag_lookup_if #(
   parameter int ADDR_SIZE = 32
) ();
   logic                 req_valid;
   logic                 req_ready;
   logic [1:0]           req_cmd;
   logic [ADDR_SIZE-1:0] req_addr;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic                 rsp_hit;
   logic [1:0]           rsp_way;
   logic [1:0]           rsp_mesi;
   logic                 rsp_evict;
   logic                 rsp_evict_dirty;
   logic [ADDR_SIZE-1:0] rsp_evict_addr;

   modport master (
      output req_valid, req_cmd, req_addr, rsp_ready,
      input  req_ready, rsp_valid, rsp_hit, rsp_way, rsp_mesi,
             rsp_evict, rsp_evict_dirty, rsp_evict_addr
   );

   modport slave (
      input  req_valid, req_cmd, req_addr, rsp_ready,
      output req_ready, rsp_valid, rsp_hit, rsp_way, rsp_mesi,
             rsp_evict, rsp_evict_dirty, rsp_evict_addr
   );
endinterface

// File: rtl/llc_tag_lookup.sv
// 4-way set-associative LLC tag directory with MESI line state and
// tree-PLRU replacement. One request at a time flows through
// IDLE -> LOOKUP -> UPDATE -> RESP; the response is held until consumed.
module llc_tag_lookup #(
   parameter int ADDR_SIZE   = 32,
   parameter int OFFSET_BITS = 6,
   parameter int INDEX_BITS  = 4
) (
   input  logic                clk,
   input  logic                rst,
   llc_tag_lookup_if.slave     bus,
   output logic [15:0]         hit_cnt,
   output logic [15:0]         miss_cnt
);
   localparam int TAG_BITS = ADDR_SIZE - INDEX_BITS - OFFSET_BITS;
   localparam int SETS     = 1 << INDEX_BITS;

   localparam logic [1:0] CMD_RD  = 2'd0;
   localparam logic [1:0] CMD_WR  = 2'd1;
   localparam logic [1:0] CMD_INV = 2'd2;
   localparam logic [1:0] CMD_CLR = 2'd3;

   localparam logic [1:0] MESI_I = 2'd0;
   localparam logic [1:0] MESI_E = 2'd2;
   localparam logic [1:0] MESI_M = 2'd3;

   typedef enum logic [1:0] {IDLE, LOOKUP, UPDATE, RESP} state_t;

   state_t state_r;
   state_t next_s;

   // Directory storage
   logic [TAG_BITS-1:0] tag_mem  [SETS][4];
   logic [1:0]          mesi_mem [SETS][4];
   logic [2:0]          plru_mem [SETS];

   // Captured request
   logic [1:0]            cmd_r;
   logic [TAG_BITS-1:0]   tag_r;
   logic [INDEX_BITS-1:0] index_r;

   // Lookup results carried into UPDATE
   logic                hit_r;
   logic [1:0]          way_r;
   logic [1:0]          vict_mesi_r;
   logic [TAG_BITS-1:0] vict_tag_r;

   // Registered response and status
   logic                 req_ready_r;
   logic                 rsp_valid_r;
   logic                 rsp_hit_r;
   logic [1:0]           rsp_way_r;
   logic [1:0]           rsp_mesi_r;
   logic                 rsp_evict_r;
   logic                 rsp_evict_dirty_r;
   logic [ADDR_SIZE-1:0] rsp_evict_addr_r;
   logic [15:0]          hit_cnt_r;
   logic [15:0]          miss_cnt_r;

   // Combinational lookup
   logic       hit_s;
   logic [1:0] hit_way_s;
   logic       inv_found_s;
   logic [1:0] inv_way_s;
   logic [1:0] victim_way_s;

   // The line offset never affects the lookup
   logic unused_offset_s;
   assign unused_offset_s = ^bus.req_addr[OFFSET_BITS-1:0];

   // Tree-PLRU update when way w is referenced: point the tree away from w
   function automatic logic [2:0] plru_touch(input logic [2:0] plru, input logic [1:0] way);
      logic [2:0] res;
      res = plru;
      if (way[1] == 1'b0) begin
         res[0] = 1'b1;
         res[1] = (way == 2'd0);
      end else begin
         res[0] = 1'b0;
         res[2] = (way == 2'd2);
      end
      return res;
   endfunction

   // Way selected by the PLRU tree {b2,b1,b0}
   function automatic logic [1:0] plru_victim(input logic [2:0] plru);
      logic [1:0] way;
      if (plru[0] == 1'b0) begin
         way = plru[1] ? 2'd1 : 2'd0;
      end else begin
         way = plru[2] ? 2'd3 : 2'd2;
      end
      return way;
   endfunction

   // Counter increment that sticks at all-ones
   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   assign bus.req_ready       = req_ready_r;
   assign bus.rsp_valid       = rsp_valid_r;
   assign bus.rsp_hit         = rsp_hit_r;
   assign bus.rsp_way         = rsp_way_r;
   assign bus.rsp_mesi        = rsp_mesi_r;
   assign bus.rsp_evict       = rsp_evict_r;
   assign bus.rsp_evict_dirty = rsp_evict_dirty_r;
   assign bus.rsp_evict_addr  = rsp_evict_addr_r;
   assign hit_cnt             = hit_cnt_r;
   assign miss_cnt            = miss_cnt_r;

   // Next-state decode of the request sequencer
   always_comb begin
      next_s = state_r;
      case (state_r)
         IDLE: begin
            if (bus.req_valid) begin
               next_s = LOOKUP;
            end else begin
               next_s = IDLE;
            end
         end
         LOOKUP: next_s = UPDATE;
         UPDATE: next_s = RESP;
         RESP: begin
            if (bus.rsp_ready) begin
               next_s = IDLE;
            end else begin
               next_s = RESP;
            end
         end
         default: next_s = IDLE;
      endcase
   end

   // State register plus handshake flags registered from the next state
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         req_ready_r <= 1'b1;
         rsp_valid_r <= 1'b0;
      end else begin
         state_r     <= next_s;
         req_ready_r <= (next_s == IDLE);
         rsp_valid_r <= (next_s == RESP);
      end
   end

   // Tag compare against the selected set and victim choice (lowest invalid way first)
   always_comb begin
      hit_s       = 1'b0;
      hit_way_s   = 2'd0;
      inv_found_s = 1'b0;
      inv_way_s   = 2'd0;
      for (int w = 3; w >= 0; w--) begin
         if ((mesi_mem[index_r][w] != MESI_I) && (tag_mem[index_r][w] == tag_r)) begin
            hit_s     = 1'b1;
            hit_way_s = 2'(w);
         end else begin
            hit_s = hit_s;
         end
         if (mesi_mem[index_r][w] == MESI_I) begin
            inv_found_s = 1'b1;
            inv_way_s   = 2'(w);
         end else begin
            inv_found_s = inv_found_s;
         end
      end
      if (inv_found_s) begin
         victim_way_s = inv_way_s;
      end else begin
         victim_way_s = plru_victim(plru_mem[index_r]);
      end
   end

   // Request capture, lookup registration, directory/counter update and response registers
   always_ff @(posedge clk) begin
      if (rst) begin
         cmd_r             <= 2'd0;
         tag_r             <= '0;
         index_r           <= '0;
         hit_r             <= 1'b0;
         way_r             <= 2'd0;
         vict_mesi_r       <= MESI_I;
         vict_tag_r        <= '0;
         rsp_hit_r         <= 1'b0;
         rsp_way_r         <= 2'd0;
         rsp_mesi_r        <= MESI_I;
         rsp_evict_r       <= 1'b0;
         rsp_evict_dirty_r <= 1'b0;
         rsp_evict_addr_r  <= '0;
         hit_cnt_r         <= 16'd0;
         miss_cnt_r        <= 16'd0;
         for (int s = 0; s < SETS; s++) begin
            plru_mem[s] <= 3'd0;
            for (int w = 0; w < 4; w++) begin
               mesi_mem[s][w] <= MESI_I;
            end
         end
      end else begin
         case (state_r)
            IDLE: begin
               if (bus.req_valid) begin
                  cmd_r   <= bus.req_cmd;
                  tag_r   <= bus.req_addr[ADDR_SIZE-1 -: TAG_BITS];
                  index_r <= bus.req_addr[OFFSET_BITS +: INDEX_BITS];
               end
            end
            LOOKUP: begin
               hit_r       <= hit_s;
               way_r       <= hit_s ? hit_way_s : victim_way_s;
               vict_mesi_r <= mesi_mem[index_r][victim_way_s];
               vict_tag_r  <= tag_mem[index_r][victim_way_s];
            end
            UPDATE: begin
               case (cmd_r)
                  CMD_RD, CMD_WR: begin
                     plru_mem[index_r] <= plru_touch(plru_mem[index_r], way_r);
                     rsp_hit_r         <= hit_r;
                     rsp_way_r         <= way_r;
                     if (hit_r) begin
                        if (cmd_r == CMD_WR) begin
                           mesi_mem[index_r][way_r] <= MESI_M;
                           rsp_mesi_r               <= MESI_M;
                        end else begin
                           rsp_mesi_r <= mesi_mem[index_r][way_r];
                        end
                        hit_cnt_r         <= sat_inc(hit_cnt_r);
                        rsp_evict_r       <= 1'b0;
                        rsp_evict_dirty_r <= 1'b0;
                        rsp_evict_addr_r  <= '0;
                     end else begin
                        mesi_mem[index_r][way_r] <= (cmd_r == CMD_WR) ? MESI_M : MESI_E;
                        rsp_mesi_r               <= (cmd_r == CMD_WR) ? MESI_M : MESI_E;
                        miss_cnt_r               <= sat_inc(miss_cnt_r);
                        rsp_evict_r              <= (vict_mesi_r != MESI_I);
                        rsp_evict_dirty_r        <= (vict_mesi_r == MESI_M);
                        rsp_evict_addr_r         <= (vict_mesi_r != MESI_I) ?
                                                    {vict_tag_r, index_r, {OFFSET_BITS{1'b0}}} : '0;
                     end
                  end
                  CMD_INV: begin
                     if (hit_r) begin
                        mesi_mem[index_r][way_r] <= MESI_I;
                     end
                     rsp_hit_r         <= hit_r;
                     rsp_way_r         <= hit_r ? way_r : 2'd0;
                     rsp_mesi_r        <= MESI_I;
                     rsp_evict_r       <= 1'b0;
                     rsp_evict_dirty_r <= 1'b0;
                     rsp_evict_addr_r  <= '0;
                  end
                  default: begin
                     for (int s = 0; s < SETS; s++) begin
                        plru_mem[s] <= 3'd0;
                        for (int w = 0; w < 4; w++) begin
                           mesi_mem[s][w] <= MESI_I;
                        end
                     end
                     hit_cnt_r         <= 16'd0;
                     miss_cnt_r        <= 16'd0;
                     rsp_hit_r         <= 1'b0;
                     rsp_way_r         <= 2'd0;
                     rsp_mesi_r        <= MESI_I;
                     rsp_evict_r       <= 1'b0;
                     rsp_evict_dirty_r <= 1'b0;
                     rsp_evict_addr_r  <= '0;
                  end
               endcase
            end
            RESP: begin
               hit_r <= hit_r;
            end
            default: begin
               hit_r <= hit_r;
            end
         endcase
      end
   end

   // Install the request tag into the chosen way on a read/write miss
   always_ff @(posedge clk) begin
      if (!rst && (state_r == UPDATE) && !hit_r && ((cmd_r == CMD_RD) || (cmd_r == CMD_WR))) begin
         tag_mem[index_r][way_r] <= tag_r;
      end
   end
endmodule

// File: tb/tb_llc_tag_lookup.sv
// Self-checking bench for llc_tag_lookup: directed vector table, hand-written
// stall / clear-all / mid-transaction reset sequences, then random traffic
// compared against a behavioural directory model.
module tb_llc_tag_lookup;
   typedef struct packed {
      logic        hit;
      logic [1:0]  way;
      logic [1:0]  mesi;
      logic        ev;
      logic        dirty;
      logic [31:0] eaddr;
      logic [15:0] hc;
      logic [15:0] mc;
   } rsp_t;

   typedef struct packed {
      logic [1:0]  cmd;
      logic [31:0] addr;
      rsp_t        exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] hit_cnt;
   logic [15:0] miss_cnt;

   int total = 0;
   int bad   = 0;

   // Behavioural directory: per set/way tag and MESI, per set the three tree bits
   int m_tag  [16][4];
   int m_mesi [16][4];
   bit m_b0 [16];
   bit m_b1 [16];
   bit m_b2 [16];
   int m_hc;
   int m_mc;

   vec_t vecs [0:12];

   always #5 clk = ~clk;

   llc_tag_lookup_if #(.ADDR_SIZE(32)) bus ();

   llc_tag_lookup #(.ADDR_SIZE(32), .OFFSET_BITS(6), .INDEX_BITS(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .hit_cnt  (hit_cnt),
      .miss_cnt (miss_cnt)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   function automatic rsp_t sample();
      rsp_t r;
      r.hit   = bus.rsp_hit;
      r.way   = bus.rsp_way;
      r.mesi  = bus.rsp_mesi;
      r.ev    = bus.rsp_evict;
      r.dirty = bus.rsp_evict_dirty;
      r.eaddr = bus.rsp_evict_addr;
      r.hc    = hit_cnt;
      r.mc    = miss_cnt;
      return r;
   endfunction

   task automatic chk_rsp(input string nm, input rsp_t g, input rsp_t e);
      chk({nm, ".hit"},   32'(g.hit),   32'(e.hit));
      chk({nm, ".way"},   32'(g.way),   32'(e.way));
      chk({nm, ".mesi"},  32'(g.mesi),  32'(e.mesi));
      chk({nm, ".evict"}, 32'(g.ev),    32'(e.ev));
      chk({nm, ".dirty"}, 32'(g.dirty), 32'(e.dirty));
      chk({nm, ".eaddr"}, g.eaddr,      e.eaddr);
      chk({nm, ".hitcnt"},  32'(g.hc),  32'(e.hc));
      chk({nm, ".misscnt"}, 32'(g.mc),  32'(e.mc));
   endtask

   task automatic model_reset();
      for (int s = 0; s < 16; s++) begin
         m_b0[s] = 1'b0; m_b1[s] = 1'b0; m_b2[s] = 1'b0;
         for (int w = 0; w < 4; w++) begin
            m_mesi[s][w] = 0;
            m_tag[s][w]  = 0;
         end
      end
      m_hc = 0;
      m_mc = 0;
   endtask

   task automatic touch(input int idx, input int w);
      if (w < 2) begin
         m_b0[idx] = 1'b1;
         m_b1[idx] = (w == 0);
      end else begin
         m_b0[idx] = 1'b0;
         m_b2[idx] = (w == 2);
      end
   endtask

   // Apply one request to the model and produce the expected response
   task automatic model(input logic [1:0] cmd, input logic [31:0] addr, output rsp_t e);
      int idx;
      int tg;
      int hw;
      int vw;
      idx = int'((addr >> 6) & 32'hF);
      tg  = int'(addr >> 10);
      hw  = -1;
      vw  = -1;
      e   = '0;
      if (cmd == 2'd3) begin
         model_reset();
      end else begin
         for (int w = 0; w < 4; w++)
            if (m_mesi[idx][w] != 0 && m_tag[idx][w] == tg) hw = w;
         if (cmd == 2'd2) begin
            if (hw >= 0) begin
               m_mesi[idx][hw] = 0;
               e.hit = 1'b1;
               e.way = 2'(hw);
            end
         end else if (hw >= 0) begin
            if (cmd == 2'd1) m_mesi[idx][hw] = 3;
            e.hit  = 1'b1;
            e.way  = 2'(hw);
            e.mesi = 2'(m_mesi[idx][hw]);
            if (m_hc < 65535) m_hc++;
            touch(idx, hw);
         end else begin
            for (int w = 3; w >= 0; w--)
               if (m_mesi[idx][w] == 0) vw = w;
            if (vw < 0) vw = (m_b0[idx] == 1'b0) ? (m_b1[idx] ? 1 : 0) : (m_b2[idx] ? 3 : 2);
            if (m_mesi[idx][vw] != 0) begin
               e.ev    = 1'b1;
               e.dirty = (m_mesi[idx][vw] == 3);
               e.eaddr = (32'(m_tag[idx][vw]) << 10) | (32'(idx) << 6);
            end
            m_tag[idx][vw]  = tg;
            m_mesi[idx][vw] = (cmd == 2'd0) ? 2 : 3;
            e.way  = 2'(vw);
            e.mesi = (cmd == 2'd0) ? 2'd2 : 2'd3;
            if (m_mc < 65535) m_mc++;
            touch(idx, vw);
         end
      end
      e.hc = 16'(m_hc);
      e.mc = 16'(m_mc);
   endtask

   // Drive one request, wait (bounded) for the response, optionally stall it
   // with rsp_ready low while checking it stays put and extra requests are refused
   task automatic do_req(input logic [1:0] cmd, input logic [31:0] addr, input int stall,
                         input bit poke, output rsp_t got, output int lat);
      int wt;
      @(negedge clk);
      bus.req_cmd   = cmd;
      bus.req_addr  = addr;
      bus.req_valid = 1'b1;
      wt = 0;
      while (bus.req_ready !== 1'b1 && wt < 20) begin
         @(negedge clk);
         wt++;
      end
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      lat = 0;
      got = '0;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (bus.rsp_valid === 1'b1) begin
            lat = n;
            break;
         end
      end
      if (lat != 0) begin
         got = sample();
         for (int s = 0; s < stall; s++) begin
            if (poke) begin
               bus.req_cmd   = 2'd1;
               bus.req_addr  = 32'hABCD_0040;
               bus.req_valid = 1'b1;
            end
            @(negedge clk);
            chk("stall.req_ready", 32'(bus.req_ready), 32'd0);
            chk("stall.rsp_valid", 32'(bus.rsp_valid), 32'd1);
            chk_rsp("stall", sample(), got);
         end
         bus.req_valid = 1'b0;
         bus.rsp_ready = 1'b1;
         @(posedge clk);
         #1;
         bus.rsp_ready = 1'b0;
      end
   endtask

   task automatic issue(input logic [1:0] cmd, input logic [31:0] addr, input int stall,
                        input bit poke, input string nm, output rsp_t got, output rsp_t exp);
      int lat;
      do_req(cmd, addr, stall, poke, got, lat);
      chk({nm, ".latency"}, 32'(lat), 32'd3);
      model(cmd, addr, exp);
   endtask

   initial begin
      rsp_t got;
      rsp_t exp;
      bit   seen;

      // rsp fields: hit, way, mesi, evict, dirty, evict_addr, hit_cnt, miss_cnt
      vecs[0]  = '{2'd0, 32'h0000_1040, '{1'b0, 2'd0, 2'd2, 1'b0, 1'b0, 32'h0,      16'd0, 16'd1}};
      vecs[1]  = '{2'd1, 32'h0000_1040, '{1'b1, 2'd0, 2'd3, 1'b0, 1'b0, 32'h0,      16'd1, 16'd1}};
      vecs[2]  = '{2'd1, 32'h0000_1040, '{1'b1, 2'd0, 2'd3, 1'b0, 1'b0, 32'h0,      16'd2, 16'd1}};
      vecs[3]  = '{2'd1, 32'h0000_1440, '{1'b0, 2'd1, 2'd3, 1'b0, 1'b0, 32'h0,      16'd2, 16'd2}};
      vecs[4]  = '{2'd1, 32'h0000_1840, '{1'b0, 2'd2, 2'd3, 1'b0, 1'b0, 32'h0,      16'd2, 16'd3}};
      vecs[5]  = '{2'd1, 32'h0000_1C40, '{1'b0, 2'd3, 2'd3, 1'b0, 1'b0, 32'h0,      16'd2, 16'd4}};
      vecs[6]  = '{2'd0, 32'h0000_1040, '{1'b1, 2'd0, 2'd3, 1'b0, 1'b0, 32'h0,      16'd3, 16'd4}};
      vecs[7]  = '{2'd0, 32'h0000_2040, '{1'b0, 2'd2, 2'd2, 1'b1, 1'b1, 32'h1840,   16'd3, 16'd5}};
      vecs[8]  = '{2'd2, 32'h0000_1047, '{1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 32'h0,      16'd3, 16'd5}};
      vecs[9]  = '{2'd0, 32'h0000_1040, '{1'b0, 2'd0, 2'd2, 1'b0, 1'b0, 32'h0,      16'd3, 16'd6}};
      vecs[10] = '{2'd2, 32'h0000_3040, '{1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 32'h0,      16'd3, 16'd6}};
      vecs[11] = '{2'd0, 32'h0000_0085, '{1'b0, 2'd0, 2'd2, 1'b0, 1'b0, 32'h0,      16'd3, 16'd7}};
      vecs[12] = '{2'd1, 32'h0000_00BF, '{1'b1, 2'd0, 2'd3, 1'b0, 1'b0, 32'h0,      16'd4, 16'd7}};

      rst           = 1'b1;
      bus.req_valid = 1'b0;
      bus.req_cmd   = 2'd0;
      bus.req_addr  = 32'h0;
      bus.rsp_ready = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("reset.req_ready", 32'(bus.req_ready), 32'd1);
      chk("reset.rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk_rsp("reset", sample(), '0);

      // Directed table
      for (int i = 0; i < 13; i++) begin
         issue(vecs[i].cmd, vecs[i].addr, 0, 1'b0, $sformatf("vec%0d", i), got, exp);
         chk_rsp($sformatf("vec%0d", i), got, vecs[i].exp);
      end

      // Response stalled five cycles while another request is presented and refused
      issue(2'd0, 32'h0000_1040, 5, 1'b1, "stall_rd", got, exp);
      chk_rsp("stall_rd", got, exp);
      issue(2'd0, 32'hABCD_0040, 0, 1'b0, "after_stall", got, exp);
      chk_rsp("after_stall", got, exp);

      // Clear-all then every read misses
      issue(2'd3, 32'h0000_1040, 0, 1'b0, "clear", got, exp);
      chk_rsp("clear", got, '0);
      issue(2'd0, 32'h0000_1040, 0, 1'b0, "clr_rd0", got, exp);
      chk("clr_rd0.miss", 32'(got.hit), 32'd0);
      chk_rsp("clr_rd0", got, exp);
      issue(2'd0, 32'h0000_0080, 0, 1'b0, "clr_rd1", got, exp);
      chk("clr_rd1.miss", 32'(got.hit), 32'd0);
      chk_rsp("clr_rd1", got, exp);

      // Reset while the request sits in LOOKUP
      @(negedge clk);
      bus.req_cmd   = 2'd0;
      bus.req_addr  = 32'h0000_1440;
      bus.req_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("midrst.req_ready", 32'(bus.req_ready), 32'd1);
      chk("midrst.rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk_rsp("midrst", sample(), '0);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         seen = seen | bus.rsp_valid;
      end
      chk("midrst.no_rsp", 32'(seen), 32'd0);
      chk("midrst.counters", {hit_cnt, miss_cnt}, 32'd0);
      issue(2'd0, 32'h0000_1040, 0, 1'b0, "post_rst", got, exp);
      chk_rsp("post_rst", got, exp);

      // Random traffic on a small tag/index footprint so hits and evictions are frequent
      for (int i = 0; i < 300; i++) begin
         logic [1:0]  cmd;
         logic [31:0] addr;
         int          r;
         r = int'($urandom_range(0, 99));
         cmd  = (r < 45) ? 2'd0 : (r < 85) ? 2'd1 : (r < 98) ? 2'd2 : 2'd3;
         addr = (32'($urandom_range(0, 6)) << 10) | (32'($urandom_range(0, 3)) << 6)
                | 32'($urandom_range(0, 63));
         issue(cmd, addr, int'($urandom_range(0, 2)), 1'b0, "rnd", got, exp);
         chk_rsp($sformatf("rnd%0d", i), got, exp);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
